// File: rtl/zorro_bus_master.sv
// zorro_bus_master
// ----------------
// Zorro II bus initiator for the SF2000 accelerator CPLD. A one-cycle START
// pulse from on-card logic requests the bus through BR/BG/BGACK. The block
// then runs a single 16-bit 68000-style read or write cycle, hands the bus
// back, and reports read data and completion status.
//
// Optional feature: define BUS_MASTER_TIMEOUT_EN to abort a cycle that sees
// no DTACK within TIMEOUT_CYCLES clocks. The abort reports ERR = 1 with DONE.
// Without the macro, the cycle waits for DTACK indefinitely and ERR is tied
// to 0.
//
// Ports
//   C7M, RESET                   bus clock, synchronous active-high reset
//   START, ADDR, WDATA, RW, BE   request; operands are latched on an
//                                accepted START
//   BUSY, DONE, ERR, RDATA       status and read data back to the requester
//   BR_n_OUT, BGACK_n_OUT        arbitration outputs (BR_n is open-drain at
//                                the top level)
//   BG_n_IN, BGACK_n_IN,         raw bus inputs; each passes through a
//   AS_n_IN, DTACK_n_IN          2-flop synchronizer
//   BUS_OE, D_OE                 tri-state enables: address/strobes, data
//   A_OUT, D_OUT, D_IN           address and data buses
//   RW_n_OUT, AS_n_OUT,          bus strobes
//   UDS_n_OUT, LDS_n_OUT
module zorro_bus_master
`ifdef BUS_MASTER_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 64
)
`endif
(
  input  logic        C7M,
  input  logic        RESET,
  input  logic        START,
  input  logic [22:0] ADDR,
  input  logic [15:0] WDATA,
  input  logic        RW,
  input  logic [1:0]  BE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        BR_n_OUT,
  input  logic        BG_n_IN,
  input  logic        BGACK_n_IN,
  input  logic        AS_n_IN,
  input  logic        DTACK_n_IN,
  output logic        BGACK_n_OUT,
  output logic        BUS_OE,
  output logic        D_OE,
  output logic [22:0] A_OUT,
  output logic [15:0] D_OUT,
  input  logic [15:0] D_IN,
  output logic        RW_n_OUT,
  output logic        AS_n_OUT,
  output logic        UDS_n_OUT,
  output logic        LDS_n_OUT
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_OWN, S_ASSERT, S_DS_W, S_WAIT, S_LATCH, S_NEGATE, S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  // Synchronizer bit order: {DTACK_n, AS_n, BGACK_n, BG_n}
  logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rw_q, rw_d;
  logic [1:0]  be_q, be_d;
  logic        timeout_hit;

  logic bg_n_s, bgack_n_s, as_n_s, dtack_n_s;
  assign {dtack_n_s, as_n_s, bgack_n_s, bg_n_s} = sync2_q;

  // The bus is free only when it has been granted to us and no other master
  // still has a cycle in progress or a grant acknowledged.
  logic bus_free;
  assign bus_free = !bg_n_s && as_n_s && dtack_n_s && bgack_n_s;

`ifdef BUS_MASTER_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  assign timeout_hit = (state_q == S_WAIT) && dtack_n_s &&
                       (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign ERR         = (state_q == S_RELEASE) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign ERR         = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge C7M) begin
    // NOTE: every register is reset here. The synchronizer stages reset to
    // the idle (high) bus level, so that no phantom grant or DTACK is seen
    // right after reset.
    if (RESET) begin
      state_q <= S_IDLE;
      sync1_q <= '1;
      sync2_q <= '1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b1;
      be_q    <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make all flops update together, so
      // the two synchronizer stages really are two stages.
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      be_q    <= be_d;
`ifdef BUS_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next state.
  always_comb begin
    // NOTE: hold-by-default assignment first, so that no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (START) state_d = S_REQ;
      S_REQ:     if (bus_free) state_d = S_OWN;
      S_OWN:     state_d = S_ASSERT;
      S_ASSERT:  state_d = rw_q ? S_WAIT : S_DS_W;
      S_DS_W:    state_d = S_WAIT;
      // DTACK is tested first, so an acknowledge on the terminal count wins.
      S_WAIT: begin
        if (!dtack_n_s)       state_d = S_LATCH;
        else if (timeout_hit) state_d = S_NEGATE;
      end
      S_LATCH:   state_d = S_NEGATE;
      S_NEGATE:  state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath: synchronizers, request capture, read data, timeout counter.
  always_comb begin
    sync1_d = {DTACK_n_IN, AS_n_IN, BGACK_n_IN, BG_n_IN};
    sync2_d = sync1_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    be_d    = be_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (state_q == S_ASSERT)    cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = cnt_q + 8'd1;
    if (timeout_hit)            err_d = 1'b1;
    if (state_q == S_IDLE && START) err_d = 1'b0;
`endif
    if (state_q == S_IDLE && START) begin
      addr_d  = ADDR;
      wdata_d = WDATA;
      rw_d    = RW;
      be_d    = BE;
    end
    if (state_q == S_LATCH && rw_q) rdata_d = D_IN;
  end

  // Bus outputs decoded from the state. Address and write data come straight
  // from the latched request, so they are stable for the whole ownership.
  logic owned;
  always_comb begin
    owned       = 1'b0;
    BR_n_OUT    = 1'b1;
    AS_n_OUT    = 1'b1;
    UDS_n_OUT   = 1'b1;
    LDS_n_OUT   = 1'b1;
    DONE        = 1'b0;
    unique case (state_q)
      S_REQ:     BR_n_OUT = 1'b0;
      S_OWN,
      S_NEGATE:  owned = 1'b1;
      S_ASSERT: begin
        owned    = 1'b1;
        AS_n_OUT = 1'b0;
        // Reads strobe with AS. Writes wait one cycle, so that data has
        // settled on the bus before the strobes fall.
        if (rw_q) {UDS_n_OUT, LDS_n_OUT} = ~be_q;
      end
      S_DS_W,
      S_WAIT,
      S_LATCH: begin
        owned    = 1'b1;
        AS_n_OUT = 1'b0;
        {UDS_n_OUT, LDS_n_OUT} = ~be_q;
      end
      S_RELEASE: DONE = 1'b1;
      default: ;
    endcase
    BUS_OE      = owned;
    BGACK_n_OUT = !owned;
    D_OE        = owned && !rw_q;
    RW_n_OUT    = owned ? rw_q : 1'b1;
  end

  assign BUSY  = (state_q != S_IDLE);
  assign RDATA = rdata_q;
  assign A_OUT = addr_q;
  assign D_OUT = wdata_q;

endmodule

// File: tb/tb_zorro_bus_master.sv
`timescale 1ns/1ps
module tb_zorro_bus_master;

  logic        C7M = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [22:0] ADDR = '0;
  logic [15:0] WDATA = '0;
  logic        RW = 1'b1;
  logic [1:0]  BE = 2'b11;
  logic        BUSY, DONE, ERR;
  logic [15:0] RDATA;
  logic        BR_n_OUT, BGACK_n_OUT, BUS_OE, D_OE;
  logic        BG_n_IN = 1'b1;
  logic        DTACK_n_IN = 1'b1;
  logic        BGACK_n_IN, AS_n_IN;
  logic [22:0] A_OUT;
  logic [15:0] D_OUT;
  logic [15:0] D_IN = '0;
  logic        RW_n_OUT, AS_n_OUT, UDS_n_OUT, LDS_n_OUT;

  always #5 C7M = ~C7M;

  zorro_bus_master dut (
    .C7M(C7M), .RESET(RESET), .START(START), .ADDR(ADDR), .WDATA(WDATA),
    .RW(RW), .BE(BE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .BR_n_OUT(BR_n_OUT), .BG_n_IN(BG_n_IN), .BGACK_n_IN(BGACK_n_IN),
    .AS_n_IN(AS_n_IN), .DTACK_n_IN(DTACK_n_IN), .BGACK_n_OUT(BGACK_n_OUT),
    .BUS_OE(BUS_OE), .D_OE(D_OE), .A_OUT(A_OUT), .D_OUT(D_OUT), .D_IN(D_IN),
    .RW_n_OUT(RW_n_OUT), .AS_n_OUT(AS_n_OUT), .UDS_n_OUT(UDS_n_OUT),
    .LDS_n_OUT(LDS_n_OUT)
  );

  // ---------------- bus environment: arbiter, other master, slave ----------
  int   bg_delay = 0;     // negedges of BR low before BG is given
  int   as_hold = 0;      // negedges another master keeps AS low after BG
  int   dtack_delay = 2;  // negedges of AS low before DTACK; -1 = never
  int   br_cnt = 0, hold_cnt = 0, as_cnt = 0;
  logic other_as_n = 1'b1;

  assign AS_n_IN    = other_as_n & (BUS_OE ? AS_n_OUT : 1'b1);
  assign BGACK_n_IN = BUS_OE ? BGACK_n_OUT : 1'b1;

  always @(negedge C7M) begin
    if (!other_as_n) begin
      hold_cnt++;
      if (hold_cnt >= as_hold) other_as_n = 1'b1;
    end
    if (!BR_n_OUT) begin
      if (BG_n_IN && br_cnt >= bg_delay) begin
        BG_n_IN = 1'b0;
        if (as_hold > 0) begin
          other_as_n = 1'b0;
          hold_cnt   = 0;
        end
      end
      br_cnt++;
    end else begin
      BG_n_IN = 1'b1;
      br_cnt  = 0;
    end
    if (!AS_n_OUT && BUS_OE) begin
      as_cnt++;
      if (dtack_delay >= 0 && as_cnt >= dtack_delay) DTACK_n_IN = 1'b0;
    end else begin
      as_cnt     = 0;
      DTACK_n_IN = 1'b1;
    end
  end

  // ---------------- monitor: per-transaction summary, index 0 = REQ -------
  int          done_count = 0;
  int          tr_n, done_idx, first_as, first_uds, first_lds, first_doe, first_bgack;
  int          br_low_n, bgack_low_n, as_low_n;
  logic [22:0] a_at_as, a_first;
  logic [15:0] dout_at_as;
  logic        rwn_at_as, a_stable, oe_seen, err_at_done, oe_at_done, bgack_at_done;

  task automatic clear_trace();
    tr_n = 0; done_idx = -1; first_as = -1; first_uds = -1; first_lds = -1;
    first_doe = -1; first_bgack = -1; br_low_n = 0; bgack_low_n = 0; as_low_n = 0;
    a_at_as = '0; a_first = '0; dout_at_as = '0; rwn_at_as = 1'b1;
    a_stable = 1'b1; oe_seen = 1'b0; err_at_done = 1'b0; oe_at_done = 1'b1;
    bgack_at_done = 1'b0;
  endtask

  initial clear_trace();

  always @(negedge C7M) begin
    if (DONE) done_count++;
    if (!BR_n_OUT) br_low_n++;
    if (!BGACK_n_OUT) begin
      bgack_low_n++;
      if (first_bgack < 0) first_bgack = tr_n;
    end
    if (!AS_n_OUT) begin
      as_low_n++;
      if (first_as < 0) begin
        first_as = tr_n; a_at_as = A_OUT; rwn_at_as = RW_n_OUT; dout_at_as = D_OUT;
      end
    end
    if (!UDS_n_OUT && first_uds < 0) first_uds = tr_n;
    if (!LDS_n_OUT && first_lds < 0) first_lds = tr_n;
    if (D_OE && first_doe < 0) first_doe = tr_n;
    if (BUS_OE) begin
      if (!oe_seen) begin oe_seen = 1'b1; a_first = A_OUT; end
      else if (A_OUT != a_first) a_stable = 1'b0;
    end
    if (DONE && done_idx < 0) begin
      done_idx = tr_n; err_at_done = ERR; oe_at_done = BUS_OE; bgack_at_done = BGACK_n_OUT;
    end
    tr_n++;
  end

  // ---------------- checking helpers --------------------------------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic start_txn(input logic rw, input logic [22:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, input logic [15:0] din, input int dly);
    @(posedge C7M); #1;
    RW = rw; ADDR = addr; WDATA = wdata; BE = be; D_IN = din; dtack_delay = dly;
    START = 1'b1;
    @(posedge C7M); #1;
    START = 1'b0;
    clear_trace();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge C7M); #1;
      if (done_idx >= 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic        rw;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] din;
    logic [15:0] exp_rdata;
    logic        exp_uds;   // UDS expected to be asserted at some point
    logic        exp_lds;
    int          exp_lag;   // cycles from AS fall to first data strobe
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int dc0;
    int fds;

    vecs[0] = '{1'b1, 23'h000100, 16'h0000, 2'b11, 16'hA55A, 16'hA55A, 1'b1, 1'b1, 0};
    vecs[1] = '{1'b0, 23'h100000, 16'h1234, 2'b10, 16'hFFFF, 16'hA55A, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b1, 23'h7FFFFF, 16'h0000, 2'b01, 16'h00C3, 16'h00C3, 1'b0, 1'b1, 0};
    vecs[3] = '{1'b0, 23'h000002, 16'hBEEF, 2'b11, 16'h0000, 16'h00C3, 1'b1, 1'b1, 1};
    vecs[4] = '{1'b1, 23'h400000, 16'h0000, 2'b10, 16'h5AA5, 16'h5AA5, 1'b1, 1'b0, 0};

    // ---- reset values
    repeat (3) @(posedge C7M);
    #1;
    check("rst_br_n",    BR_n_OUT, 1);
    check("rst_bgack_n", BGACK_n_OUT, 1);
    check("rst_as_n",    AS_n_OUT, 1);
    check("rst_uds_n",   UDS_n_OUT, 1);
    check("rst_lds_n",   LDS_n_OUT, 1);
    check("rst_rw_n",    RW_n_OUT, 1);
    check("rst_bus_oe",  BUS_OE, 0);
    check("rst_d_oe",    D_OE, 0);
    check("rst_busy",    BUSY, 0);
    check("rst_done",    DONE, 0);
    check("rst_err",     ERR, 0);
    check("rst_rdata",   RDATA, 0);
    check("rst_a_out",   A_OUT, 0);
    check("rst_d_out",   D_OUT, 0);
    RESET = 1'b0;
    repeat (3) @(posedge C7M);

    // ---- table: immediate grant, DTACK 2 cycles after AS
    // Grant seen at REQ index 0 reaches the FSM at index 2, so OWN is index 3,
    // ASSERT 4, DTACK visible at 7, LATCH 8, NEGATE 9, RELEASE (DONE) 10.
    for (int v = 0; v < 5; v++) begin
      start_txn(vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].be, vecs[v].din, 2);
      wait_done(200, ok);
      check($sformatf("v%0d_done_seen", v), ok, 1);
      check($sformatf("v%0d_done_idx", v), done_idx, 10);
      check($sformatf("v%0d_err", v), err_at_done, 0);
      check($sformatf("v%0d_rdata", v), RDATA, vecs[v].exp_rdata);
      check($sformatf("v%0d_br_low", v), br_low_n, 3);
      check($sformatf("v%0d_first_bgack", v), first_bgack, 3);
      check($sformatf("v%0d_bgack_low", v), bgack_low_n, 7);
      check($sformatf("v%0d_first_as", v), first_as, 4);
      check($sformatf("v%0d_addr", v), a_at_as, vecs[v].addr);
      check($sformatf("v%0d_addr_stable", v), a_stable, 1);
      check($sformatf("v%0d_rw_n", v), rwn_at_as, vecs[v].rw);
      check($sformatf("v%0d_uds_used", v), first_uds >= 0, vecs[v].exp_uds);
      check($sformatf("v%0d_lds_used", v), first_lds >= 0, vecs[v].exp_lds);
      fds = (first_uds >= 0 && (first_lds < 0 || first_uds < first_lds)) ? first_uds : first_lds;
      check($sformatf("v%0d_ds_lag", v), fds - first_as, vecs[v].exp_lag);
      check($sformatf("v%0d_d_oe_first", v), first_doe, vecs[v].rw ? -1 : 3);
      if (!vecs[v].rw) check($sformatf("v%0d_d_out", v), dout_at_as, vecs[v].wdata);
      check($sformatf("v%0d_released", v), oe_at_done, 0);
    end

    // ---- late grant: BG after 20 cycles of BR -> OWN at index 23
    bg_delay = 20; as_hold = 0;
    start_txn(1'b1, 23'h012345, 16'h0, 2'b11, 16'hC001, 2);
    wait_done(200, ok);
    check("lateg_done_seen", ok, 1);
    check("lateg_first_bgack", first_bgack, 23);
    check("lateg_br_low", br_low_n, 23);
    check("lateg_done_idx", done_idx, 30);
    check("lateg_rdata", RDATA, 16'hC001);

    // ---- late grant plus another master holding AS 5 cycles -> OWN at 28
    as_hold = 5;
    start_txn(1'b1, 23'h012346, 16'h0, 2'b11, 16'hC002, 2);
    wait_done(200, ok);
    check("ashold_done_seen", ok, 1);
    check("ashold_first_bgack", first_bgack, 28);
    check("ashold_done_idx", done_idx, 35);
    check("ashold_rdata", RDATA, 16'hC002);
    bg_delay = 0; as_hold = 0;

    // ---- DTACK visible exactly on the 64th wait cycle: normal completion
    start_txn(1'b1, 23'h000040, 16'h0, 2'b11, 16'h6363, 63);
    wait_done(300, ok);
    check("tc_dtack_done_seen", ok, 1);
    check("tc_dtack_done_idx", done_idx, 71);
    check("tc_dtack_err", err_at_done, 0);
    check("tc_dtack_rdata", RDATA, 16'h6363);

`ifdef BUS_MASTER_TIMEOUT_EN
    // ---- timeout: ASSERT plus 64 counted wait cycles, then NEGATE/RELEASE
    start_txn(1'b1, 23'h000041, 16'h0, 2'b11, 16'hDEAD, -1);
    wait_done(300, ok);
    check("tmo_done_seen", ok, 1);
    check("tmo_done_idx", done_idx, 70);
    check("tmo_as_low", as_low_n, 65);
    check("tmo_err", err_at_done, 1);
    check("tmo_rdata_kept", RDATA, 16'h6363);
    check("tmo_released_oe", oe_at_done, 0);
    check("tmo_released_bgack", bgack_at_done, 1);
`else
    // ---- without a timeout the cycle waits for DTACK indefinitely
    start_txn(1'b1, 23'h000041, 16'h0, 2'b11, 16'h7777, -1);
    wait_done(150, ok);
    check("hold_no_done", ok, 0);
    check("hold_busy", BUSY, 1);
    check("hold_as_n", AS_n_OUT, 0);
    dtack_delay = 0;
    wait_done(50, ok);
    check("hold_done_seen", ok, 1);
    check("hold_err", err_at_done, 0);
    check("hold_rdata", RDATA, 16'h7777);
`endif

    // ---- reset while in WAIT: bus released at the next edge, no DONE
    start_txn(1'b1, 23'h000050, 16'h0, 2'b11, 16'h4321, -1);
    repeat (8) @(posedge C7M);
    #1;
    check("mid_in_wait_as_n", AS_n_OUT, 0);
    dc0 = done_count;
    RESET = 1'b1;
    @(posedge C7M); #1;
    check("mid_rst_bus_oe", BUS_OE, 0);
    check("mid_rst_bgack_n", BGACK_n_OUT, 1);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_done", DONE, 0);
    check("mid_rst_as_n", AS_n_OUT, 1);
    check("mid_rst_rdata", RDATA, 0);
    RESET = 1'b0;
    dtack_delay = 2;
    repeat (20) @(posedge C7M);
    #1;
    check("mid_rst_no_done", done_count - dc0, 0);

    // ---- START while BUSY is dropped; latched request unchanged
    dc0 = done_count;
    start_txn(1'b0, 23'h0ABCDE, 16'h1357, 2'b11, 16'h0, 2);
    @(posedge C7M); #1;
    ADDR = 23'h000007; RW = 1'b1; WDATA = 16'h0000; START = 1'b1;
    @(posedge C7M); #1;
    START = 1'b0;
    repeat (3) @(posedge C7M);
    #1;
    ADDR = 23'h000001; START = 1'b1;
    @(posedge C7M); #1;
    START = 1'b0;
    wait_done(200, ok);
    check("busy_start_done_seen", ok, 1);
    check("busy_start_addr", a_at_as, 23'h0ABCDE);
    check("busy_start_addr_stable", a_stable, 1);
    check("busy_start_rw_n", rwn_at_as, 0);
    check("busy_start_d_out", dout_at_as, 16'h1357);
    repeat (20) @(posedge C7M);
    #1;
    check("busy_start_one_done", done_count - dc0, 1);
    check("busy_start_idle", BUSY, 0);

    // ---- START in the cycle right after DONE is accepted
    start_txn(1'b1, 23'h000060, 16'h0, 2'b11, 16'h1111, 2);
    wait_done(200, ok);
    check("b2b_first_done", ok, 1);
    RW = 1'b1; ADDR = 23'h000061; BE = 2'b11; D_IN = 16'h0F0F; START = 1'b1;
    @(posedge C7M); #1;
    START = 1'b0;
    clear_trace();
    check("b2b_busy", BUSY, 1);
    wait_done(200, ok);
    check("b2b_second_done", ok, 1);
    check("b2b_addr", a_at_as, 23'h000061);
    check("b2b_rdata", RDATA, 16'h0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
